// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Legal byte-enable patterns are only enforced when DMEM_ERR_EN is defined.
package dmem_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_e;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // Naturally aligned byte, halfword or word masks.
    function automatic logic be_legal(input logic [3:0] be);
        return be inside {BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W};
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store byte-lane request/response bus between core (master) and memory (slave).
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] addr;
    logic [3:0]  byte_enable;
    logic [31:0] w_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid,
        output req_we,
        output addr,
        output byte_enable,
        output w_data,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  addr,
        input  byte_enable,
        input  w_data,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );

endinterface

// File: rtl/dmem_byte_ram.sv
// Four 8-bit banks sharing one word index; per-lane write enable, asynchronous word read.
module dmem_byte_ram #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [3:0]            lane_we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           w_data,
    output logic [31:0]           r_data
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] bank [Depth];

        always_ff @(posedge clk) begin
            if (lane_we[g]) begin
                bank[idx] <= w_data[8*g +: 8];
            end
        end

        assign r_data[8*g +: 8] = bank[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts one request, waits WAIT_CYCLES, then commits/reads and responds.
// Optional DMEM_ERR_EN flags out-of-range addresses and unaligned lane masks via rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] WaitInit = WAIT_CNT_W'(WAIT_CYCLES);
    localparam bit                    ZeroWait = (WAIT_CYCLES == 0);

    dmem_state_e           state_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_data_q;
    logic [WAIT_CNT_W-1:0] cnt_q;

    logic                  we_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;

    logic                  accept;
    logic                  in_wait;
    logic                  resp_fire;
    logic                  in_err;
    logic [ADDR_WIDTH-1:0] in_idx;
    logic                  op_we;
    logic                  op_err;
    logic [ADDR_WIDTH-1:0] op_idx;
    logic [3:0]            op_be;
    logic [31:0]           op_wdata;
    logic [3:0]            lane_we;
    logic [31:0]           rd_word;
    logic                  unused_addr;

    assign in_idx      = bus.addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{bus.addr[1:0], bus.addr[31:ADDR_WIDTH+2]};

`ifdef DMEM_ERR_EN
    assign in_err = (bus.addr[31:ADDR_WIDTH+2] != '0) || !be_legal(bus.byte_enable);
`else
    assign in_err = 1'b0;
`endif

    assign accept  = bus.req_valid && req_ready_q;
    assign in_wait = (state_q == StWait);

    // With zero wait states the response edge is the acceptance edge, so use live inputs.
    assign resp_fire = in_wait ? (cnt_q == WAIT_CNT_W'(1)) : (accept && ZeroWait);
    assign op_we     = in_wait ? we_q    : bus.req_we;
    assign op_err    = in_wait ? err_q   : in_err;
    assign op_idx    = in_wait ? idx_q   : in_idx;
    assign op_be     = in_wait ? be_q    : bus.byte_enable;
    assign op_wdata  = in_wait ? wdata_q : bus.w_data;

    assign lane_we = (resp_fire && op_we && !op_err && !reset) ? op_be : 4'b0000;

    dmem_byte_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .lane_we(lane_we),
        .idx    (op_idx),
        .w_data (op_wdata),
        .r_data (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            if (resp_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= (op_we || op_err) ? 32'h0 : rd_word;
                rsp_err_q   <= op_err;
            end

            case (state_q)
                StIdle, StResp: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        err_q   <= in_err;
                        idx_q   <= in_idx;
                        be_q    <= bus.byte_enable;
                        wdata_q <= bus.w_data;
                        if (ZeroWait) begin
                            state_q     <= StResp;
                            req_ready_q <= 1'b1;
                        end else begin
                            state_q     <= StWait;
                            cnt_q       <= WaitInit;
                            req_ready_q <= 1'b0;
                        end
                    end else begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - WAIT_CNT_W'(1);
                    if (cnt_q == WAIT_CNT_W'(1)) begin
                        state_q     <= StResp;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (WAIT_CYCLES 0, 1, 3) checked against a lane-merging model.
// Error-flag expectations follow DMEM_ERR_EN when it is defined.
module tb_dmem_responder;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [31:0] mdl [3][1024];

    dmem_if bus0 ();
    dmem_if bus1 ();
    dmem_if bus3 ();

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .reset(rst_a), .bus(bus0));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .reset(rst_a), .bus(bus1));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .reset(rst_b), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic ready_of(input int d);
        case (d)
            0:       return bus0.req_ready;
            1:       return bus1.req_ready;
            default: return bus3.req_ready;
        endcase
    endfunction

    function automatic logic valid_of(input int d);
        case (d)
            0:       return bus0.rsp_valid;
            1:       return bus1.rsp_valid;
            default: return bus3.rsp_valid;
        endcase
    endfunction

    function automatic logic [31:0] data_of(input int d);
        case (d)
            0:       return bus0.rsp_data;
            1:       return bus1.rsp_data;
            default: return bus3.rsp_data;
        endcase
    endfunction

    function automatic logic err_of(input int d);
        case (d)
            0:       return bus0.rsp_err;
            1:       return bus1.rsp_err;
            default: return bus3.rsp_err;
        endcase
    endfunction

    function automatic int lat_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic drive(input int d, input logic v, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        case (d)
            0: begin
                bus0.req_valid = v; bus0.req_we = we; bus0.addr = a;
                bus0.byte_enable = be; bus0.w_data = wd;
            end
            1: begin
                bus1.req_valid = v; bus1.req_we = we; bus1.addr = a;
                bus1.byte_enable = be; bus1.w_data = wd;
            end
            default: begin
                bus3.req_valid = v; bus3.req_we = we; bus3.addr = a;
                bus3.byte_enable = be; bus3.w_data = wd;
            end
        endcase
    endtask

    // Present a request, hold until accepted, and (if track) push the model's expected response.
    task automatic do_req(input int d, input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input bit keep, input bit track);
        int          n;
        logic        rdy;
        logic        err;
        logic [9:0]  ix;
        exp_t        e;
        drive(d, 1'b1, we, a, be, wd);
        n = 0;
        do begin
            @(negedge clk);
            rdy = ready_of(d);
            n++;
        end while (!rdy && n < 20);
        if (!rdy) begin
            check_eq("req_accept_timeout", 32'd0, 32'd1);
            drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            return;
        end
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the responder must use its latched copy.
        if (!keep) drive(d, 1'b0, ~we, a ^ 32'h4, ~be, ~wd);
        ix  = a[11:2];
        err = 1'b0;
`ifdef DMEM_ERR_EN
        err = (a[31:12] != 20'h0) ||
              !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
`endif
        if (track) begin
            e.dut = d;
            e.err = err;
            e.cyc = cyc;
            if (we) begin
                e.data = 32'h0;
                if (!err) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) mdl[d][ix][8*i +: 8] = wd[8*i +: 8];
                    end
                end
            end else begin
                e.data = err ? 32'h0 : mdl[d][ix];
            end
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain_pending", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (valid_of(d) === 1'b1) begin
                int   k;
                exp_t e;
                k = -1;
                for (int i = 0; i < sb.size() && k < 0; i++) begin
                    if (sb[i].dut == d) k = i;
                end
                if (k < 0) begin
                    check_eq("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb[k];
                    sb.delete(k);
                    check_eq("rsp_data", data_of(d), e.data);
                    check_eq("rsp_err", {31'b0, err_of(d)}, {31'b0, e.err});
                    check_eq("rsp_latency", cyc - e.cyc, lat_of(d));
                end
            end else if (!rst_a && !rst_b) begin
                check_eq("rsp_idle_data", data_of(d), 32'h0);
            end
        end
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check_eq("reset_ready", {31'b0, ready_of(d)}, 32'd1);
            check_eq("reset_valid", {31'b0, valid_of(d)}, 32'd0);
            check_eq("reset_data", data_of(d), 32'h0);
            check_eq("reset_err", {31'b0, err_of(d)}, 32'd0);
        end

        // WAIT_CYCLES=1: word, byte lane and halfword merges.
        do_req(1, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1);
        do_req(1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 1'b1);
        do_req(1, 1'b1, 32'h12, 4'b0100, 32'h00AA0000, 1'b0, 1'b1);
        do_req(1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 1'b1);
        do_req(1, 1'b1, 32'h20, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b1);
        do_req(1, 1'b1, 32'h20, 4'b1100, 32'h12340000, 1'b0, 1'b1);
        do_req(1, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b0, 1'b1);
        // Upper address bits alias (or error when the check is enabled).
        do_req(1, 1'b0, 32'h1010, 4'b1111, 32'h0, 1'b0, 1'b1);
        // Odd lane mask and out-of-range store.
        do_req(1, 1'b1, 32'h10, 4'b0110, 32'h55555555, 1'b0, 1'b1);
        do_req(1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 1'b1);
        do_req(1, 1'b1, 32'h0, 4'b1111, 32'h11111111, 1'b0, 1'b1);
        do_req(1, 1'b1, 32'h0001_0000, 4'b1111, 32'h22222222, 1'b0, 1'b1);
        do_req(1, 1'b0, 32'h0, 4'b1111, 32'h0, 1'b0, 1'b1);
        drain();

        // WAIT_CYCLES=0: back-to-back stores then loads, ready held high throughout.
        for (int i = 0; i < 8; i++) begin
            check_eq("b2b_ready", {31'b0, bus0.req_ready}, 32'd1);
            do_req(0, 1'b1, i * 4, 4'b1111, 32'hA5A50000 ^ (i * 32'h01010101), 1'b1, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            check_eq("b2b_ready", {31'b0, bus0.req_ready}, 32'd1);
            do_req(0, 1'b0, i * 4, 4'b1111, 32'h0, 1'b1, 1'b1);
        end
        bus0.req_valid = 1'b0;
        do_req(0, 1'b1, 32'h4, 4'b0000, 32'hFFFFFFFF, 1'b0, 1'b1);
        do_req(0, 1'b0, 32'h4, 4'b1111, 32'h0, 1'b0, 1'b1);
        drain();

        // WAIT_CYCLES=3: reset while a store is waiting discards it.
        do_req(2, 1'b1, 32'h40, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b1);
        drain();
        do_req(2, 1'b1, 32'h40, 4'b1111, 32'h0BADBAD0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        check_eq("mid_wait_reset_ready", {31'b0, bus3.req_ready}, 32'd1);
        check_eq("mid_wait_reset_valid", {31'b0, bus3.rsp_valid}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        do_req(2, 1'b0, 32'h40, 4'b1111, 32'h0, 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
